// File: rtl/md_unit_if.sv
// Request/writeback bundle for the iterative multiply/divide unit.
// The master side issues a request (start/op/a/b/rd). The slave side is md_unit,
// which reports busy and returns a one-cycle register-file write.
interface md_unit_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [AW-1:0]   rd;
  logic            busy;
  logic            done;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output start, op, a, b, rd,
    input  busy, done, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  start, op, a, b, rd,
    output busy, done, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative 32-bit unsigned multiply / divide unit with register-file writeback.
// op: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
// Each operation takes one edge to accept and 32 iteration edges, then spends one DONE cycle.
// The result is written back during that DONE cycle, and no write is made when rd is 0.
// Optional feature macro MD_UNIT_DIV_EN:
//   defined   -> restoring divider for DIVU/REMU. Divide by zero gives all-ones / dividend.
//   undefined -> no divider. DIVU/REMU finish after one RUN cycle with result 0.
module md_unit #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic       clk,
  input logic       rst,
  md_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

  state_t            state_r;
  state_t            state_nxt_s;

  // Latched request
  logic [1:0]        op_r;
  logic [AW-1:0]     rd_r;
  logic [5:0]        cnt_r;

  // Shared datapath.
  // For multiply: acc_r is the 64-bit product accumulator, opa_r is the multiplicand
  // (shifted left each iteration), and opb_r is the multiplier (shifted right each iteration).
  // For divide: acc_r holds the remainder in the upper half and the dividend/quotient in the
  // lower half, and opa_r[XLEN-1:0] holds the divisor.
  logic [2*XLEN-1:0] acc_r;
  logic [2*XLEN-1:0] opa_r;
  logic [XLEN-1:0]   opb_r;

  logic [2*XLEN-1:0] acc_nxt_s;
  logic [2*XLEN-1:0] opa_nxt_s;
  logic [XLEN-1:0]   opb_nxt_s;
  logic [2*XLEN-1:0] mul_sum_s;
  logic              last_iter_s;
  logic              finish_s;
  logic [XLEN-1:0]   result_s;

`ifdef MD_UNIT_DIV_EN
  logic [XLEN:0]     rem_sh_s;
  logic [XLEN:0]     diff_s;
`endif

  // Registered outputs
  logic              busy_r;
  logic              done_r;
  logic              wb_en_r;
  logic [AW-1:0]     wb_addr_r;
  logic [XLEN-1:0]   wb_data_r;

  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic              wb_en_nxt_s;
  logic [AW-1:0]     wb_addr_nxt_s;
  logic [XLEN-1:0]   wb_data_nxt_s;

  // Decide whether the current RUN edge is the final one.
  // Without the divider, a divide op leaves RUN immediately.
  always_comb begin
    last_iter_s = 1'b0;
`ifdef MD_UNIT_DIV_EN
    last_iter_s = (cnt_r == CNT_LAST);
`else
    last_iter_s = (cnt_r == CNT_LAST) || op_r[1];
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_iter_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One iteration step for the current operation: shift-add or restoring divide
  always_comb begin
    acc_nxt_s = acc_r;
    opa_nxt_s = opa_r;
    opb_nxt_s = opb_r;
    mul_sum_s = acc_r + (opb_r[0] ? opa_r : {(2*XLEN){1'b0}});
`ifdef MD_UNIT_DIV_EN
    rem_sh_s  = acc_r[2*XLEN-1:XLEN-1];
    diff_s    = rem_sh_s - {1'b0, opa_r[XLEN-1:0]};
`endif
    if (!op_r[1]) begin
      acc_nxt_s = mul_sum_s;
      opa_nxt_s = opa_r << 1;
      opb_nxt_s = opb_r >> 1;
    end else begin
`ifdef MD_UNIT_DIV_EN
      // A non-negative trial difference means the divisor fits: subtract it and emit a 1.
      if (!diff_s[XLEN]) begin
        acc_nxt_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
`else
      acc_nxt_s = acc_r;
`endif
    end
  end

  // Select the result word from the post-iteration datapath value
  always_comb begin
    result_s = {XLEN{1'b0}};
    case (op_r)
      2'b00:   result_s = acc_nxt_s[XLEN-1:0];
      2'b01:   result_s = acc_nxt_s[2*XLEN-1:XLEN];
`ifdef MD_UNIT_DIV_EN
      2'b10:   result_s = acc_nxt_s[XLEN-1:0];
      2'b11:   result_s = acc_nxt_s[2*XLEN-1:XLEN];
`endif
      default: result_s = {XLEN{1'b0}};
    endcase
  end

  // Latch the request in IDLE, then advance the datapath once per RUN edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= 2'b00;
      rd_r  <= {AW{1'b0}};
      cnt_r <= 6'd0;
      acc_r <= {(2*XLEN){1'b0}};
      opa_r <= {(2*XLEN){1'b0}};
      opb_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            op_r  <= bus.op;
            rd_r  <= bus.rd;
            cnt_r <= 6'd0;
            if (bus.op[1]) begin
              acc_r <= {{XLEN{1'b0}}, bus.a};
              opa_r <= {{XLEN{1'b0}}, bus.b};
              opb_r <= {XLEN{1'b0}};
            end else begin
              acc_r <= {(2*XLEN){1'b0}};
              opa_r <= {{XLEN{1'b0}}, bus.a};
              opb_r <= bus.b;
            end
          end
        end
        ST_RUN: begin
          acc_r <= acc_nxt_s;
          opa_r <= opa_nxt_s;
          opb_r <= opb_nxt_s;
          cnt_r <= cnt_r + 6'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Next output values. Writeback fields are nonzero only for the cycle entering DONE.
  always_comb begin
    finish_s      = (state_r == ST_RUN) && (state_nxt_s == ST_DONE);
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    done_nxt_s    = finish_s;
    wb_en_nxt_s   = 1'b0;
    wb_addr_nxt_s = {AW{1'b0}};
    wb_data_nxt_s = {XLEN{1'b0}};
    if (finish_s) begin
      wb_en_nxt_s   = (rd_r != {AW{1'b0}});
      wb_addr_nxt_s = rd_r;
      wb_data_nxt_s = result_s;
    end else begin
      wb_en_nxt_s   = 1'b0;
    end
  end

  // Output registers, so no input reaches an output combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      wb_en_r   <= 1'b0;
      wb_addr_r <= {AW{1'b0}};
      wb_data_r <= {XLEN{1'b0}};
    end else begin
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      wb_en_r   <= wb_en_nxt_s;
      wb_addr_r <= wb_addr_nxt_s;
      wb_data_r <= wb_data_nxt_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.wb_en   = wb_en_r;
  assign bus.wb_addr = wb_addr_r;
  assign bus.wb_data = wb_data_r;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32: operand/result width; only 32 is supported.
REQ-002 SHALL provide parameter AW, default 5: register-address width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 op  input  2  operation: 00 MUL (low 32), 01 MULHU (high 32 unsigned), 10 DIVU, 11 REMU.
REQ-008 a  input  XLEN  operand 1, driven from the register-file read port o1.
REQ-009 b  input  XLEN  operand 2, driven from the register-file read port o2.
REQ-010 rd  input  AW  destination register for the result.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 wb_en  output  1  write strobe to the register-file regwrite input.
REQ-014 wb_addr  output  AW  write address to the register-file W input.
REQ-015 wb_data  output  XLEN  write data to the register-file data input.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; rst forces IDLE.
REQ-017 IDLE with start=1 at edge E0 SHALL latch a, b, op and rd, clear a 6-bit iteration counter, and enter RUN.
REQ-018 RUN SHALL perform one iteration per edge on E1..E32; after E32 the FSM SHALL be in DONE.
REQ-019 MUL and MULHU SHALL use unsigned shift-add into a 64-bit accumulator; MUL returns bits [31:0] and MULHU returns bits [63:32].
REQ-020 DIVU and REMU SHALL use unsigned restoring division (one quotient bit per iteration); DIVU returns the quotient and REMU returns the remainder.
REQ-021 Divide by zero SHALL complete with the same latency; DIVU returns 32'hFFFFFFFF and REMU returns the latched a.
REQ-022 DONE SHALL last exactly one cycle, with done=1, wb_data=result, wb_addr=latched rd, and wb_en=1 unless latched rd==0.
REQ-023 If latched rd==0, done SHALL still pulse and wb_en SHALL stay 0.
REQ-024 Outside DONE, done, wb_en, wb_addr and wb_data SHALL all be 0.
REQ-025 start SHALL be ignored in RUN and DONE; no request is queued.
REQ-026 Changes on a, b, op or rd after E0 SHALL NOT affect the result.
REQ-027 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-028 On rst=1, without waiting for a clock edge: state=IDLE, busy=0, done=0, wb_en=0, wb_addr=0, wb_data=0, counter=0, datapath registers=0.
REQ-029 rst asserted during RUN or DONE SHALL abort the operation; no wb_en pulse SHALL follow.
REQ-030 With rst=1 and start=1 together, the request SHALL be dropped; a request at the first edge after rst deasserts SHALL be accepted.

Configuration
REQ-031 Macro MD_UNIT_DIV_EN defined: DIVU/REMU SHALL behave per REQ-020/REQ-021.
REQ-032 Macro MD_UNIT_DIV_EN undefined: no divider logic; op 10/11 SHALL go IDLE -> DONE at E1 with wb_data=0, and wb_en follows REQ-022/REQ-023.
REQ-033 MUL/MULHU behaviour and latency SHALL be identical in both builds.

Verification
REQ-034 MUL a=6 b=7 rd=3 -> busy for 33 cycles; done and wb_en high exactly one cycle after E32; wb_addr=3, wb_data=42.
REQ-035 MUL then MULHU, each with a=b=32'hFFFFFFFF -> wb_data=32'h00000001, then 32'hFFFFFFFE.
REQ-036 MD_UNIT_DIV_EN defined: DIVU 100/7 rd=5 -> wb_data=14; REMU 100/7 -> 2; DIVU 32'h1234/0 -> 32'hFFFFFFFF; REMU 32'h1234/0 -> 32'h1234.
REQ-037 Start MUL 3x5 rd=4; pulse start with op=01 a=9 b=9 at RUN cycle 5; change a at cycle 6 -> single done, wb_data=15, no second result.
REQ-038 MUL 2x2 rd=0 -> done pulses, wb_en stays 0; then rst at RUN cycle 10 of a new request -> busy, done and wb_en drop to 0 before the next edge, and no writeback occurs.
REQ-039 MD_UNIT_DIV_EN undefined: DIVU 100/7 rd=2 -> done at E1, wb_en=1, wb_addr=2, wb_data=0.
